// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode slot, EX/MEM forwarding sources, and registered EX outputs.
// The stage itself connects through the slave modport; the decode/pipeline side uses master.
interface id_ex_stage_if #(
    parameter int DATA_W    = 16,
    parameter int ALUCTRL_W = 3,
    parameter int BRANCH_W  = 3,
    parameter int REG_W     = 3
);
    logic                 STALL;
    logic                 FLUSH;
    logic                 ID_VALID;
    logic [ALUCTRL_W-1:0] ID_ALUCTRL;
    logic [BRANCH_W-1:0]  ID_BRANCH;
    logic [REG_W-1:0]     ID_RS1;
    logic [REG_W-1:0]     ID_RS2;
    logic [REG_W-1:0]     ID_RD;
    logic [DATA_W-1:0]    ID_RDATA1;
    logic [DATA_W-1:0]    ID_RDATA2;
    logic [DATA_W-1:0]    ID_IMM;
    logic                 ID_USEIMM;
    logic                 ID_REGWRITE;
    logic                 ID_MEMREAD;
    logic                 ID_MEMWRITE;
    logic [DATA_W-1:0]    ALUOUT;
    logic                 MEM_REGWRITE;
    logic [REG_W-1:0]     MEM_RD;
    logic [DATA_W-1:0]    MEM_DATA;

    logic                 EX_VALID;
    logic [ALUCTRL_W-1:0] EX_ALUCTRL;
    logic [BRANCH_W-1:0]  EX_BRANCH;
    logic [DATA_W-1:0]    EX_DATA1;
    logic [DATA_W-1:0]    EX_DATA2;
    logic [DATA_W-1:0]    EX_RS2VAL;
    logic [REG_W-1:0]     EX_RD;
    logic                 EX_REGWRITE;
    logic                 EX_MEMREAD;
    logic                 EX_MEMWRITE;
    logic                 HOLD;

    modport slave (
        input  STALL, FLUSH, ID_VALID, ID_ALUCTRL, ID_BRANCH, ID_RS1, ID_RS2, ID_RD,
               ID_RDATA1, ID_RDATA2, ID_IMM, ID_USEIMM, ID_REGWRITE, ID_MEMREAD,
               ID_MEMWRITE, ALUOUT, MEM_REGWRITE, MEM_RD, MEM_DATA,
        output EX_VALID, EX_ALUCTRL, EX_BRANCH, EX_DATA1, EX_DATA2, EX_RS2VAL, EX_RD,
               EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, HOLD
    );

    modport master (
        output STALL, FLUSH, ID_VALID, ID_ALUCTRL, ID_BRANCH, ID_RS1, ID_RS2, ID_RD,
               ID_RDATA1, ID_RDATA2, ID_IMM, ID_USEIMM, ID_REGWRITE, ID_MEMREAD,
               ID_MEMWRITE, ALUOUT, MEM_REGWRITE, MEM_RD, MEM_DATA,
        input  EX_VALID, EX_ALUCTRL, EX_BRANCH, EX_DATA1, EX_DATA2, EX_RS2VAL, EX_RD,
               EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, HOLD
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding from EX/MEM, load-use bubble with decode hold,
// and squash on taken branch. All EX outputs are registered; only HOLD is combinational.
module id_ex_stage #(
    parameter int DATA_W    = 16,
    parameter int ALUCTRL_W = 3,
    parameter int BRANCH_W  = 3,
    parameter int REG_W     = 3
) (
    input  logic            CLK,
    input  logic            RST,
    id_ex_stage_if.slave    bus
);
    typedef struct packed {
        logic                 valid;
        logic [ALUCTRL_W-1:0] aluctrl;
        logic [BRANCH_W-1:0]  branch;
        logic [DATA_W-1:0]    data1;
        logic [DATA_W-1:0]    data2;
        logic [DATA_W-1:0]    rs2val;
        logic [REG_W-1:0]     rd;
        logic                 regwrite;
        logic                 memread;
        logic                 memwrite;
    } ex_t;

    ex_t ex_q, ex_d, capt;

    logic              ex_fwd_ok;
    logic              rs2_used;
    logic              lu;
    logic [DATA_W-1:0] fwd1, fwd2;

    // A load in EX has no result yet, so only non-load writers forward from ALUOUT.
    assign ex_fwd_ok = ex_q.valid & ex_q.regwrite & ~ex_q.memread;

    function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0]  s,
                                              input logic [DATA_W-1:0] rdata);
        if (s == '0)
            return '0;
        else if (ex_fwd_ok && ex_q.rd == s)
            return bus.ALUOUT;
        else if (bus.MEM_REGWRITE && bus.MEM_RD == s)
            return bus.MEM_DATA;
        else
            return rdata;
    endfunction

    assign fwd1 = fwd(bus.ID_RS1, bus.ID_RDATA1);
    assign fwd2 = fwd(bus.ID_RS2, bus.ID_RDATA2);

    // Stores read rs2 as store data even though DATA2 carries the offset.
    assign rs2_used = ~bus.ID_USEIMM | bus.ID_MEMWRITE;

    assign lu = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & bus.ID_VALID &
                ((bus.ID_RS1 == ex_q.rd) | (rs2_used & (bus.ID_RS2 == ex_q.rd)));

    assign bus.HOLD = bus.STALL | (lu & ~bus.FLUSH);

    always_comb begin
        capt          = '0;
        capt.valid    = 1'b1;
        capt.aluctrl  = bus.ID_ALUCTRL;
        capt.branch   = bus.ID_BRANCH;
        capt.data1    = fwd1;
        capt.data2    = bus.ID_USEIMM ? bus.ID_IMM : fwd2;
        capt.rs2val   = fwd2;
        capt.rd       = bus.ID_RD;
        capt.regwrite = bus.ID_REGWRITE;
        capt.memread  = bus.ID_MEMREAD;
        capt.memwrite = bus.ID_MEMWRITE;
    end

    always_comb begin
        ex_d = ex_q;
        if (bus.FLUSH)
            ex_d = '0;
        else if (bus.STALL)
            ex_d = ex_q;
        else if (lu || !bus.ID_VALID)
            ex_d = '0;
        else
            ex_d = capt;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign bus.EX_VALID    = ex_q.valid;
    assign bus.EX_ALUCTRL  = ex_q.aluctrl;
    assign bus.EX_BRANCH   = ex_q.branch;
    assign bus.EX_DATA1    = ex_q.data1;
    assign bus.EX_DATA2    = ex_q.data2;
    assign bus.EX_RS2VAL   = ex_q.rs2val;
    assign bus.EX_RD       = ex_q.rd;
    assign bus.EX_REGWRITE = ex_q.regwrite;
    assign bus.EX_MEMREAD  = ex_q.memread;
    assign bus.EX_MEMWRITE = ex_q.memwrite;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 16-bit CPU, directly upstream of the ALU and branch comparator. It captures the decoded instruction each cycle and resolves operand forwarding from the EX and MEM stages. It detects load-use hazards, inserting a bubble and holding decode for one cycle, and it squashes the entry on a taken branch. Its registered outputs drive the ALU and comparator inputs (ALUCTRL, BRANCH, DATA1, DATA2) directly.

## Interface
- DATA_W, 16, datapath width
- ALUCTRL_W, 3, ALU operation code width (codes 0..7)
- BRANCH_W, 3, branch code width (0 none, 1 always, 2 gt, 3 lt, 4 eq)
- REG_W, 3, register index width; register 0 reads as zero and is never a forwarding target

- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous reset, active-high
- STALL  in  1  external freeze (memory wait); holds all registers
- FLUSH  in  1  taken-branch squash (comparator PCSRC)
- ID_VALID  in  1  decode slot holds a real instruction
- ID_ALUCTRL  in  ALUCTRL_W  ALU operation
- ID_BRANCH  in  BRANCH_W  branch code
- ID_RS1, ID_RS2, ID_RD  in  REG_W  source/destination indices
- ID_RDATA1, ID_RDATA2  in  DATA_W  register-file read data
- ID_IMM  in  DATA_W  sign/zero-extended immediate
- ID_USEIMM  in  1  DATA2 takes the immediate
- ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE  in  1  control bits
- ALUOUT  in  DATA_W  current ALU result of the instruction held in this block
- MEM_REGWRITE  in  1  MEM-stage instruction writes a register
- MEM_RD  in  REG_W  MEM-stage destination
- MEM_DATA  in  DATA_W  MEM-stage write-back value (ALU result or load data)
- EX_VALID  out  1  stage holds a real instruction
- EX_ALUCTRL  out  ALUCTRL_W  to ALU
- EX_BRANCH  out  BRANCH_W  to comparator
- EX_DATA1  out  DATA_W  forwarded rs1 value, to ALU DATA1 and comparator DATA1
- EX_DATA2  out  DATA_W  ALU DATA2: immediate or forwarded rs2
- EX_RS2VAL  out  DATA_W  forwarded rs2 value, to comparator DATA2 and store data
- EX_RD  out  REG_W  destination
- EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE  out  1  control bits
- HOLD  out  1  decode/fetch must not advance this cycle

## Operation
- Update priority per edge: RST > FLUSH > STALL > load-use bubble > capture.
- RST: all outputs 0 (EX_VALID, controls, EX_BRANCH, EX_ALUCTRL, data, EX_RD).
- FLUSH: load a bubble. All control outputs and data are 0, and EX_BRANCH is 0, so PCSRC deasserts next cycle.
- STALL: every register keeps its value.
- Bubble (control outputs and data 0) replaces ID_* contents.
- Capture: latch ID_* with forwarded operands.
- A bubble is all-zero controls, so it never writes a register, accesses memory, or branches.
- Load-use hazard LU = EX_VALID & EX_MEMREAD & EX_RD≠0 & ID_VALID & (ID_RS1==EX_RD | (rs2used & ID_RS2==EX_RD)), where rs2used = !ID_USEIMM | ID_MEMWRITE.
- Forwarding, per source index s (rs1, rs2), first match wins:
  - s==0 → 0
  - EX_VALID & EX_REGWRITE & !EX_MEMREAD & EX_RD==s → ALUOUT
  - MEM_REGWRITE & MEM_RD==s → MEM_DATA
  - else ID_RDATAx
- EX_DATA2 = ID_USEIMM ? ID_IMM : fwd(rs2).
- EX_RS2VAL = fwd(rs2) always.
- HOLD = STALL | (LU & !FLUSH). Combinational from registered EX state, ID inputs and STALL.
- When ID_VALID=0, the slot captures as a bubble (controls 0) and LU is 0.

## Timing
- Latency 1 cycle: ID_* sampled at edge N appear on EX_* after edge N. Only HOLD is combinational.
- Load-use lasts exactly 1 cycle:
  - The bubble makes EX_VALID=0 the next cycle, clearing LU.
  - The load now sits in MEM and forwards via MEM_DATA.
- FLUSH with STALL in the same cycle: flush wins.
- FLUSH with LU in the same cycle: flush wins and HOLD reflects STALL only.
- RST mid-stall or mid-hazard: outputs cleared on that edge, HOLD=STALL the following cycle.
- Forwarding is width-exact DATA_W; there is no arithmetic in this block.

## Test plan
- Reset: RST=1 for one edge with arbitrary ID_* → all EX_* 0, HOLD=0. First capture after release passes ID_ALUCTRL=1, RS1=2, RDATA1=0x1234 through unchanged.
- EX forwarding, via the reg-reg ALU path: instruction A (RD=3, REGWRITE) is in EX with ALUOUT=0x00FF, and B in ID has RS1=3, RDATA1=0xDEAD → EX_DATA1=0x00FF.
- EX-over-MEM priority: with the same setup plus MEM_RD=3, MEM_DATA=0x0001 → EX_DATA1=0x00FF.
- Load-use: LW to r4 in EX, ID has RS2=4 with USEIMM=0 → HOLD=1 for 1 cycle and EX_VALID=0 next. On the following edge the instruction captures with EX_DATA2=MEM_DATA (load value 0xBEEF).
- Flush: FLUSH=1 together with STALL=1 and a valid ID instruction → next cycle EX_VALID=0, EX_BRANCH=0, EX_REGWRITE=0.
- r0 / immediate: RS1=0 while MEM_RD=0 with MEM_DATA=0x5555 → EX_DATA1=0. USEIMM=1 with IMM=0x0010 and RS2 matching a load in EX → no hazard, EX_DATA2=0x0010.
